// File: rtl/scan_sequencer.sv
// Multi-segment ramp scan sequencer: a host-written segment table of min/max/increment/dwell
// entries is stepped through for a number of passes, driving the scan value bus q.
module scan_sequencer #(
  parameter int NSEG = 4,
  parameter int QW   = 16,
  parameter int DW   = 10,
  localparam int AW  = $clog2(NSEG),
  localparam int SW  = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [1:0]    cfg_field,
  input  logic [QW-1:0] cfg_data,
  input  logic [SW-1:0] num_seg,
  input  logic [7:0]    repeat_cnt,
  input  logic          start,
  input  logic          abort,
  output logic [QW-1:0] q,
  output logic          output_upd,
  output logic          busy,
  output logic [AW-1:0] seg_idx,
  output logic          done,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_EMIT    = 3'd2,
    S_DWELL   = 3'd3,
    S_NEXTSEG = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] tmin_q [NSEG];
  logic [QW-1:0] tmin_d [NSEG];
  logic [QW-1:0] tmax_q [NSEG];
  logic [QW-1:0] tmax_d [NSEG];
  logic [QW-1:0] tinc_q [NSEG];
  logic [QW-1:0] tinc_d [NSEG];
  logic [DW-1:0] tdw_q  [NSEG];
  logic [DW-1:0] tdw_d  [NSEG];
  logic [QW-1:0] q_q, q_d;
  logic [QW-1:0] wmax_q, wmax_d;
  logic [QW-1:0] winc_q, winc_d;
  logic [DW-1:0] wdw_q, wdw_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          upd_q, upd_d;
  logic [AW-1:0] seg_q, seg_d;
  logic [SW-1:0] nseg_q, nseg_d;
  logic [7:0]    rem_q, rem_d;

  logic [SW-1:0] nseg_in;
  logic [SW-1:0] seg_nxt;
  logic [QW:0]   next_val;
  logic          step_ok;
  logic          expire;

  // Config bus: cfg_we is a single-cycle strobe with no back-pressure; a write is
  // taken on the edge it is high only while the sequencer is idle, otherwise dropped.
  always_comb begin
    nseg_in = num_seg;
    if (num_seg == '0) begin
      nseg_in = SW'(1);
    end else if (num_seg > SW'(NSEG)) begin
      nseg_in = SW'(NSEG);
    end
    seg_nxt  = {1'b0, seg_q} + SW'(1);
    next_val = {1'b0, q_q} + {1'b0, winc_q};
    step_ok  = (winc_q != '0) && !next_val[QW] && (next_val[QW-1:0] <= wmax_q);
    expire   = ((state_q == S_EMIT) && (wdw_q == DW'(1))) ||
               ((state_q == S_DWELL) && (cnt_q == DW'(1)));
  end

  always_comb begin
    state_d = state_q;
    tmin_d  = tmin_q;
    tmax_d  = tmax_q;
    tinc_d  = tinc_q;
    tdw_d   = tdw_q;
    q_d     = q_q;
    wmax_d  = wmax_q;
    winc_d  = winc_q;
    wdw_d   = wdw_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    seg_d   = seg_q;
    nseg_d  = nseg_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          case (cfg_field)
            2'd0:    tmin_d[cfg_addr] = cfg_data;
            2'd1:    tmax_d[cfg_addr] = cfg_data;
            2'd2:    tinc_d[cfg_addr] = cfg_data;
            default: tdw_d[cfg_addr]  = cfg_data[DW-1:0];
          endcase
        end
        if (start && !abort) begin
          nseg_d  = nseg_in;
          rem_d   = repeat_cnt;
          seg_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wmax_d  = tmax_q[seg_q];
        winc_d  = tinc_q[seg_q];
        wdw_d   = (tdw_q[seg_q] == '0) ? DW'(1) : tdw_q[seg_q];
        q_d     = tmin_q[seg_q];
        upd_d   = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        // A dwell of one leaves no DWELL cycle: the step decision is made here.
        if (!expire) begin
          cnt_d   = wdw_q - DW'(1);
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (!expire) begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      S_NEXTSEG: begin
        if (seg_nxt < nseg_q) begin
          seg_d   = seg_q + AW'(1);
          state_d = S_LOAD;
        end else if ((rem_q == 8'd0) || (rem_q > 8'd1)) begin
          if (rem_q != 8'd0) begin
            rem_d = rem_q - 8'd1;
          end
          seg_d   = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (expire) begin
      if (step_ok) begin
        q_d     = next_val[QW-1:0];
        upd_d   = 1'b1;
        state_d = S_EMIT;
      end else begin
        state_d = S_NEXTSEG;
      end
    end

    // Abort overrides everything above: q freezes and no pending update is issued.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      q_d     = q_q;
      upd_d   = 1'b0;
      seg_d   = seg_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NSEG; i++) begin
        tmin_q[i] <= '0;
        tmax_q[i] <= '0;
        tinc_q[i] <= '0;
        tdw_q[i]  <= '0;
      end
      q_q    <= '0;
      wmax_q <= '0;
      winc_q <= '0;
      wdw_q  <= '0;
      cnt_q  <= '0;
      upd_q  <= 1'b0;
      seg_q  <= '0;
      nseg_q <= '0;
      rem_q  <= '0;
    end else begin
      state_q <= state_d;
      tmin_q  <= tmin_d;
      tmax_q  <= tmax_d;
      tinc_q  <= tinc_d;
      tdw_q   <= tdw_d;
      q_q     <= q_d;
      wmax_q  <= wmax_d;
      winc_q  <= winc_d;
      wdw_q   <= wdw_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      seg_q   <= seg_d;
      nseg_q  <= nseg_d;
      rem_q   <= rem_d;
    end
  end

  assign q          = q_q;
  assign output_upd = upd_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done       = (state_q == S_FINISH);
  assign seg_idx    = seg_q;
  assign state_dbg  = state_q;

endmodule
